ad_capture: RTL and testbench

//  Receive-side counterpart of the DA signal generator: drives ad_clk, samples the 8-bit ADC bus,

---
 rtl/ad_capture_pkg.sv | 31 +++
 rtl/ad_sample_ram.sv | 40 ++++
 rtl/ad_capture.sv | 155 +++++++++++++++
 tb/tb_ad_capture.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_capture_pkg.sv
`default_nettype none
// ============================================================================
// ad_capture_pkg : capture FSM states, trigger slope codes, edge-compare helper
// Rev 1.0
// ============================================================================
package ad_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_e;

    localparam logic C_SLOPE_RISE = 1'b0;
    localparam logic C_SLOPE_FALL = 1'b1;

    function automatic logic edge_hit(input logic slope, input logic [7:0] level,
                                      input logic [7:0] prev, input logic [7:0] cur);
        logic hit;
        case (slope)
            C_SLOPE_RISE: hit = (prev < level) && (cur >= level);
            C_SLOPE_FALL: hit = (prev > level) && (cur <= level);
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad_sample_ram.sv
`default_nettype none
// ============================================================================
// ad_sample_ram : simple dual-port sample store, one write port, registered read
// Rev 1.0
// ============================================================================
module ad_sample_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [2**AW];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array itself holds no state of interest.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/ad_capture.sv
`default_nettype none
// ============================================================================
// ad_capture : ADC timebase, edge trigger and pre/post-trigger frame capture
// Rev 1.0
// ============================================================================
module ad_capture
    import ad_capture_pkg::*;
#(
    parameter int AW        = 10,
    parameter int PRE_TRIG  = 512,
    parameter int AUTO_TRIG = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [1:0]    div_sel_i,
    input  logic [7:0]    trig_level_i,
    input  logic          trig_slope_i,
    input  logic [7:0]    ad_data_in_i,
    output logic          ad_clk_o,
    input  logic          frame_ack_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_valid_o,
    output logic          frame_ready_o,
    output logic          auto_trig_o,
    output logic          busy_o
);

    localparam int DEPTH  = 2**AW;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam int CW     = (AW + 1 > $clog2(AUTO_TRIG + 1)) ? AW + 1 : $clog2(AUTO_TRIG + 1);

    cap_state_e    state_q;
    logic [1:0]    div_q;
    logic [3:0]    phase_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] trig_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    cur_q;
    logic          auto_trig_q;
    logic          rd_valid_q;

    logic [3:0]    phase_last;
    logic [3:0]    phase_half;
    logic          phase_wrap;
    logic          busy;
    logic          strobe;
    logic          start;
    logic          trig_hit;
    logic          trig_force;
    logic          rd_accept;
    logic [AW-1:0] rd_phys;

    assign phase_last = 4'((5'd2 << div_q) - 5'd1);
    assign phase_half = 4'd1 << div_q;
    assign phase_wrap = (phase_q == phase_last);
    assign busy       = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign strobe     = busy && phase_wrap;
    assign start      = (state_q == ST_IDLE) || ((state_q == ST_DONE) && frame_ack_i);

    // cnt_q == 0 marks the first ARMED sample, whose predecessor belongs to PRE.
    assign trig_hit   = (cnt_q != '0) && edge_hit(trig_slope_i, trig_level_i, cur_q, ad_data_in_i);
    assign trig_force = (AUTO_TRIG != 0) && (cnt_q == CW'(AUTO_TRIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            phase_q     <= '0;
            wptr_q      <= '0;
            trig_ptr_q  <= '0;
            cnt_q       <= '0;
            cur_q       <= '0;
            auto_trig_q <= 1'b0;
        end else if (!en_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
        end else if (start) begin
            state_q     <= ST_PRE;
            div_q       <= div_sel_i;
            phase_q     <= '0;
            wptr_q      <= '0;
            cnt_q       <= '0;
            auto_trig_q <= 1'b0;
        end else begin
            phase_q <= phase_wrap ? 4'd0 : phase_q + 4'd1;
            if (strobe) begin
                cur_q  <= ad_data_in_i;
                wptr_q <= wptr_q + 1'b1;
                case (state_q)
                    ST_PRE: begin
                        if (cnt_q == CW'(PRE_TRIG - 1)) begin
                            state_q <= ST_ARMED;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_hit || trig_force) begin
                            trig_ptr_q  <= wptr_q;
                            auto_trig_q <= !trig_hit;
                            cnt_q       <= '0;
                            state_q     <= (POST_N == 0) ? ST_DONE : ST_POST;
                        end else if (~&cnt_q) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_POST: begin
                        if (cnt_q == CW'(POST_N - 1)) begin
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_accept = (state_q == ST_DONE) && rd_en_i;
    assign rd_phys   = trig_ptr_q - AW'(PRE_TRIG) + rd_addr_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
        end
    end

    ad_sample_ram #(
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (strobe),
        .waddr_i (wptr_q),
        .wdata_i (ad_data_in_i),
        .re_i    (rd_accept),
        .raddr_i (rd_phys),
        .rdata_o (rd_data_o)
    );

    assign ad_clk_o      = busy && (phase_q < phase_half);
    assign rd_valid_o    = rd_valid_q;
    assign frame_ready_o = (state_q == ST_DONE);
    assign auto_trig_o   = auto_trig_q;
    assign busy_o        = busy;

endmodule
`default_nettype wire

// File: tb/tb_ad_capture.sv
`default_nettype none
// ============================================================================
// tb_ad_capture : self-checking bench for ad_capture (large and small frames)
// Rev 1.0
// ============================================================================
module tb_ad_capture;

    localparam int SM_PRE  = 8;
    localparam int SM_AUTO = 16;

    logic       clk = 1'b0;
    logic       rst, en, slope, ack, rd_en;
    logic [1:0] div_sel;
    logic [7:0] lvl, ad_data;
    logic [9:0] rd_addr;

    logic       adclk_b, rv_b, fr_b, at_b, busy_b;
    logic       adclk_s, rv_s, fr_s, at_s, busy_s;
    logic [7:0] rd_b, rd_s;

    logic       adclk_m, rv_m, fr_m, at_m, busy_m;
    logic [7:0] rd_m;
    bit         sel = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         mode = 0;
    int         idx = 0;
    logic [7:0] smp[$];

    typedef struct {
        int         addr;
        logic [7:0] exp;
    } rd_vec_t;
    rd_vec_t tbl[6];

    always #5 clk = ~clk;

    ad_capture #(.AW(10), .PRE_TRIG(512), .AUTO_TRIG(4096)) dut_b (
        .clk(clk), .rst(rst), .en_i(en), .div_sel_i(div_sel), .trig_level_i(lvl),
        .trig_slope_i(slope), .ad_data_in_i(ad_data), .ad_clk_o(adclk_b), .frame_ack_i(ack),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_b), .rd_valid_o(rv_b),
        .frame_ready_o(fr_b), .auto_trig_o(at_b), .busy_o(busy_b));

    ad_capture #(.AW(4), .PRE_TRIG(SM_PRE), .AUTO_TRIG(SM_AUTO)) dut_s (
        .clk(clk), .rst(rst), .en_i(en), .div_sel_i(div_sel), .trig_level_i(lvl),
        .trig_slope_i(slope), .ad_data_in_i(ad_data), .ad_clk_o(adclk_s), .frame_ack_i(ack),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr[3:0]), .rd_data_o(rd_s), .rd_valid_o(rv_s),
        .frame_ready_o(fr_s), .auto_trig_o(at_s), .busy_o(busy_s));

    assign adclk_m = sel ? adclk_s : adclk_b;
    assign rv_m    = sel ? rv_s    : rv_b;
    assign fr_m    = sel ? fr_s    : fr_b;
    assign at_m    = sel ? at_s    : at_b;
    assign busy_m  = sel ? busy_s  : busy_b;
    assign rd_m    = sel ? rd_s    : rd_b;

    // ADC model: a new conversion result appears on every rising ad_clk.
    always @(posedge adclk_m) begin : adc_model
        logic [7:0] v;
        case (mode)
            0:       v = idx[7:0];
            1:       v = idx[0] ? 8'hF0 : 8'h10;
            2:       v = 8'h40;
            default: v = 8'($urandom_range(0, 255));
        endcase
        ad_data = v;
        smp.push_back(v);
        idx++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input int a, input logic [7:0] exp, input string nm);
        rd_en   = 1'b1;
        rd_addr = 10'(a);
        @(negedge clk);
        rd_en = 1'b0;
        chk({nm, " valid"}, int'(rv_m), 1);
        chk(nm, int'(rd_m), int'(exp));
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!fr_m && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " frame_ready"}, int'(fr_m), 1);
    endtask

    task automatic start(input int m, input logic [7:0] l, input logic s, input logic [1:0] d);
        en = 1'b0;
        @(negedge clk);
        mode = m; lvl = l; slope = s; div_sel = d;
        smp.delete();
        idx = 0;
        en = 1'b1;
    endtask

    function automatic bit hit(input logic [7:0] p, input logic [7:0] c,
                               input logic [7:0] l, input logic s);
        if (s) return (p > l) && (c <= l);
        return (p < l) && (c >= l);
    endfunction

    // Index of the trigger sample in the recorded stream, -1 if none.
    function automatic int find_trig(input int pre, input int auto_n, input logic [7:0] l,
                                     input logic s, output bit forced);
        forced = 1'b0;
        for (int k = pre; k < smp.size(); k++) begin
            if (k > pre && hit(smp[k-1], smp[k], l, s)) return k;
            if (auto_n != 0 && k - pre + 1 == auto_n) begin
                forced = 1'b1;
                return k;
            end
        end
        return -1;
    endfunction

    initial begin
        logic [15:0] pat;
        logic [7:0]  pat8;
        int          t;
        bit          forced;
        bit          seen;

        tbl[0] = '{512,  8'd100};
        tbl[1] = '{0,    8'd100};
        tbl[2] = '{513,  8'd101};
        tbl[3] = '{155,  8'd255};
        tbl[4] = '{156,  8'd0};
        tbl[5] = '{1023, 8'd99};

        rst = 1'b1; en = 1'b0; slope = 1'b0; ack = 1'b0; rd_en = 1'b0;
        div_sel = 2'd0; lvl = 8'd0; rd_addr = '0; ad_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset busy",        int'(busy_b),  0);
        chk("reset frame_ready", int'(fr_b),    0);
        chk("reset ad_clk",      int'(adclk_b), 0);
        chk("reset rd_valid",    int'(rv_b),    0);
        chk("reset rd_data",     int'(rd_b),    0);
        chk("reset auto_trig",   int'(at_b),    0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp, P = 4, rising trigger at 100
        sel = 1'b0;
        start(0, 8'd100, 1'b0, 2'd1);
        pat = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pat = {pat[14:0], adclk_m};
        end
        chk("ad_clk div4 pattern", int'(pat), 16'hCCCC);
        rd_en = 1'b1; rd_addr = 10'd5;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        chk("rd outside DONE", int'(rv_m), 0);
        wait_done(8000, "ramp");
        chk("ramp auto_trig", int'(at_m), 0);
        chk("ramp busy", int'(busy_m), 0);
        for (int i = 0; i < 6; i++) rd(tbl[i].addr, tbl[i].exp, "ramp rd");

        // Read and re-arm in the same cycle; next frame is a falling square wave
        mode = 1; lvl = 8'h80; slope = 1'b1; div_sel = 2'd0;
        smp.delete();
        idx = 0;
        rd_en = 1'b1; ack = 1'b1; rd_addr = 10'd512;
        @(negedge clk);
        rd_en = 1'b0; ack = 1'b0;
        chk("ack+rd valid", int'(rv_m), 1);
        chk("ack+rd data", int'(rd_m), 100);
        chk("ack+rd busy", int'(busy_m), 1);
        chk("ack+rd frame_ready", int'(fr_m), 0);
        div_sel = 2'd3;
        pat8 = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat8 = {pat8[6:0], adclk_m};
        end
        chk("div_sel latched", int'(pat8), 8'h55);
        wait_done(4000, "square");
        chk("square auto_trig", int'(at_m), 0);
        rd(512, 8'h10, "square rd trig");
        rd(511, 8'hF0, "square rd pre");
        rd(0,   8'h10, "square rd first");
        rd(1023, 8'hF0, "square rd last");

        en = 1'b0;
        @(negedge clk);
        chk("en low busy", int'(busy_m), 0);
        chk("en low frame_ready", int'(fr_m), 0);

        // Small frame: AW=4, PRE_TRIG=8, trigger at wptr 3
        sel = 1'b1;
        start(0, 8'd19, 1'b0, 2'd0);
        wait_done(2000, "wrap");
        chk("wrap auto_trig", int'(at_m), 0);
        rd(0,  8'd11, "wrap rd0");
        rd(15, 8'd26, "wrap rd15");
        rd(8,  8'd19, "wrap rd8");

        // Constant input never crosses: forced trigger
        start(2, 8'h80, 1'b0, 2'd0);
        wait_done(2000, "auto");
        chk("auto auto_trig", int'(at_m), 1);
        for (int a = 0; a < 16; a++) rd(a, 8'h40, "auto rd");

        // en dropped during ARMED
        start(2, 8'h80, 1'b0, 2'd0);
        repeat (20) @(negedge clk);
        chk("armed busy", int'(busy_m), 1);
        en = 1'b0;
        @(negedge clk);
        chk("en drop busy", int'(busy_m), 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fr_m) seen = 1'b1;
        end
        chk("en drop no frame_ready", int'(seen), 0);

        // Reset mid-POST
        start(0, 8'd19, 1'b0, 2'd0);
        repeat (46) @(negedge clk);
        chk("post busy", int'(busy_m), 1);
        rst = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        chk("rst busy", int'(busy_m), 0);
        chk("rst frame_ready", int'(fr_m), 0);
        chk("rst ad_clk", int'(adclk_m), 0);
        chk("rst rd_valid", int'(rv_m), 0);
        rst = 1'b0; rd_en = 1'b0; en = 1'b0;
        @(negedge clk);

        // Randomised frames against the sample-stream model
        for (int f = 0; f < 10; f++) begin
            start(3, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
            wait_done(2000, "rnd");
            t = find_trig(SM_PRE, SM_AUTO, lvl, slope, forced);
            checks++;
            if (t < SM_PRE || t + 7 >= smp.size()) begin
                errors++;
                $display("FAIL rnd model trigger: got %0d samples %0d", t, smp.size());
            end else begin
                chk("rnd auto_trig", int'(at_m), int'(forced));
                for (int a = 0; a < 16; a++) rd(a, smp[t - SM_PRE + a], "rnd rd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
